uart_cmd_bridge: RTL

//  Command decoder between the UART receive and transmit byte streams, used where
//  the design needs register access instead of plain echo.
//  - Parses framed commands from the rx stream and runs one read or write on a

---
 rtl/uart_cmd_bridge.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses W/R/P frames from rx, runs one register bus access, returns one tx byte.
// Latency: response valid one cycle after the last frame byte or after bus_ack; bus_req rises one cycle after the last byte.
// Backpressure: rx_ready drops outside the parse states; the response is held until tx_ready. Optional checksum: UART_CMD_BRIDGE_CHECKSUM_EN.
module uart_cmd_bridge #(
    parameter int GAP_TIMEOUT = 50000,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic [7:0] cmd_count,
    output logic       abort
);

`ifdef UART_CMD_BRIDGE_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_P = 8'h50;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RESP
    } state_t;

    state_t        state;
    logic [7:0]    op;
    logic [7:0]    csum;
    logic          resp_ok;
    logic [GW-1:0] gap_cnt;
    logic [BW-1:0] bus_cnt;
    logic          rx_fire;
    logic          in_frame;

    assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
    assign rx_ready = !reset && ((state == S_IDLE) || in_frame);
    assign rx_fire  = rx_valid && rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            op        <= 8'h00;
            csum      <= 8'h00;
            resp_ok   <= 1'b0;
            gap_cnt   <= '0;
            bus_cnt   <= '0;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            cmd_count <= 8'h00;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;

            // A byte arriving in the expiry cycle wins over the abort.
            if (!in_frame || rx_fire) begin
                gap_cnt <= '0;
            end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
                gap_cnt <= '0;
                abort   <= 1'b1;
                state   <= S_IDLE;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        op   <= rx_byte;
                        csum <= rx_byte;
                        if (rx_byte == OP_W || rx_byte == OP_R) begin
                            state <= S_ADDR;
                        end else if (rx_byte == OP_P && CSUM_EN) begin
                            state <= S_CSUM;
                        end else if (rx_byte == OP_P) begin
                            tx_byte  <= OP_P;
                            tx_valid <= 1'b1;
                            resp_ok  <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            tx_byte  <= NAK;
                            tx_valid <= 1'b1;
                            resp_ok  <= 1'b0;
                            state    <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        bus_addr <= rx_byte;
                        csum     <= csum ^ rx_byte;
                        if (op == OP_W) begin
                            state <= S_DATA;
                        end else if (CSUM_EN) begin
                            state <= S_CSUM;
                        end else begin
                            bus_req <= 1'b1;
                            bus_we  <= 1'b0;
                            bus_cnt <= '0;
                            state   <= S_BUS;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        bus_wdata <= rx_byte;
                        csum      <= csum ^ rx_byte;
                        if (CSUM_EN) begin
                            state <= S_CSUM;
                        end else begin
                            bus_req <= 1'b1;
                            bus_we  <= 1'b1;
                            bus_cnt <= '0;
                            state   <= S_BUS;
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_fire) begin
                        if (rx_byte != csum) begin
                            tx_byte  <= NAK;
                            tx_valid <= 1'b1;
                            resp_ok  <= 1'b0;
                            state    <= S_RESP;
                        end else if (op == OP_P) begin
                            tx_byte  <= OP_P;
                            tx_valid <= 1'b1;
                            resp_ok  <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            bus_req <= 1'b1;
                            bus_we  <= (op == OP_W);
                            bus_cnt <= '0;
                            state   <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the final timeout cycle still counts as success.
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        tx_byte  <= bus_we ? ACK : bus_rdata;
                        tx_valid <= 1'b1;
                        resp_ok  <= 1'b1;
                        state    <= S_RESP;
                    end else if (bus_cnt == BW'(BUS_TIMEOUT - 1)) begin
                        bus_req  <= 1'b0;
                        tx_byte  <= NAK;
                        tx_valid <= 1'b1;
                        resp_ok  <= 1'b0;
                        state    <= S_RESP;
                    end else begin
                        bus_cnt <= bus_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                        if (resp_ok) cmd_count <= cmd_count + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
